// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Opcodes, frame width and FSM state encoding shared by the SPI
//               master controller and the slave / RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam logic [2:0] OP_WR_ADDR = 3'b000;
    localparam logic [2:0] OP_WR_DATA = 3'b001;
    localparam logic [2:0] OP_RD_ADDR = 3'b110;
    localparam logic [2:0] OP_RD_DATA = 3'b111;

    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        TURN  = 3'd3,
        READ  = 3'd4,
        HOLD  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================================
// Module      : spi_shift_reg
// Description : 11-bit parallel-load / MSB-first shift-out register with an
//               independent 8-bit shift-in path for MISO data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_reg
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_frame,
    input  logic                  shift_out,
    input  logic                  shift_in,
    input  logic                  miso,
    output logic                  tx_bit,
    output logic [7:0]            rx_byte
);

    logic [FRAME_BITS-1:0] r_tx;
    logic [7:0]            r_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= '0;
            r_rx <= '0;
        end else begin
            if (load) begin
                r_tx <= load_frame;
            end else if (shift_out) begin
                r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
            if (shift_in) begin
                r_rx <= {r_rx[6:0], miso};
            end
        end
    end

    assign tx_bit  = r_tx[FRAME_BITS-1];
    assign rx_byte = r_rx;

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI master turning parallel commands into 11-bit MOSI frames
//               and returning read-data bytes sampled from MISO.
//               Optional macro SPI_MASTER_OP_CHECK_EN rejects opcodes
//               010/011/100/101 with a cmd_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       cmd_err
);

    localparam logic [3:0] c_shift_last = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_turn_last  = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] c_hold_last  = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] c_read_last  = 4'd7;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_rd_flag;

    logic       w_accept;
    logic       w_illegal;
    logic       w_load;
    logic       w_shift_out;
    logic       w_shift_in;
    logic       w_tx_bit;
    logic [7:0] w_rx_byte;

    assign w_accept = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_OP_CHECK_EN
    // Legal opcodes have op[2]==op[1]; the mixed patterns are unused by the slave.
    assign w_illegal = cmd_op[2] ^ cmd_op[1];
`else
    assign w_illegal = 1'b0;
`endif

    assign w_load      = w_accept && !w_illegal;
    assign w_shift_out = (r_state == START) || ((r_state == SHIFT) && (r_cnt != 4'd0));
    assign w_shift_in  = (r_state == READ);

    spi_shift_reg u_shift_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_frame ({cmd_op, cmd_data}),
        .shift_out  (w_shift_out),
        .shift_in   (w_shift_in),
        .miso       (MISO),
        .tx_bit     (w_tx_bit),
        .rx_byte    (w_rx_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_rd_flag <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            cmd_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cmd_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            cmd_err <= 1'b1;
                        end else begin
                            r_state   <= START;
                            SS_n      <= 1'b0;
                            MOSI      <= 1'b0;
                            cmd_ready <= 1'b0;
                            r_rd_flag <= (cmd_op == OP_RD_DATA);
                        end
                    end
                end
                START: begin
                    r_state <= SHIFT;
                    r_cnt   <= c_shift_last;
                    MOSI    <= w_tx_bit;
                end
                SHIFT: begin
                    if (r_cnt == 4'd0) begin
                        MOSI <= 1'b0;
                        if (r_rd_flag) begin
                            r_state <= TURN;
                            r_cnt   <= c_turn_last;
                        end else begin
                            r_state <= HOLD;
                            r_cnt   <= c_hold_last;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        MOSI  <= w_tx_bit;
                    end
                end
                TURN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= READ;
                        r_cnt   <= c_read_last;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                READ: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= HOLD;
                        r_cnt   <= c_hold_last;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= IDLE;
                        SS_n      <= 1'b1;
                        cmd_ready <= 1'b1;
                        if (r_rd_flag) begin
                            rd_data  <= w_rx_byte;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Scoreboard bench for spi_master_ctrl with a behavioural SPI
//               slave / RAM model; honours SPI_MASTER_OP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int TURN   = 2;
    localparam int HOLD   = 1;
    localparam int LEN_WR = 1 + 11 + HOLD;
    localparam int LEN_RD = 1 + 11 + TURN + 8 + HOLD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'b000;
    logic [7:0] cmd_data = 8'h00;
    logic       miso = 1'b0;
    logic       cmd_ready, ss_n, mosi, rd_valid, cmd_err;
    logic [7:0] rd_data;

    logic       v4 = 1'b0;
    logic [2:0] op4 = 3'b000;
    logic [7:0] d4 = 8'h00;
    logic       miso4 = 1'b0;
    logic       rdy4, ss4, mosi4, rv4, err4;
    logic [7:0] rd4;

    always #5 clk = ~clk;

    spi_master_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
        .rd_valid(rd_valid), .rd_data(rd_data), .cmd_err(cmd_err)
    );

    spi_master_ctrl #(.TURN_CYCLES(4), .HOLD_CYCLES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v4), .cmd_ready(rdy4),
        .cmd_op(op4), .cmd_data(d4), .SS_n(ss4), .MOSI(mosi4), .MISO(miso4),
        .rd_valid(rv4), .rd_data(rd4), .cmd_err(err4)
    );

    int pass_cnt = 0;
    int total = 0;

    logic [10:0] exp_frame[$], obs_frame[$];
    int          exp_len[$], obs_len[$];
    logic [7:0]  exp_rd[$], obs_rd[$];
    int          len4_q[$];
    logic [7:0]  rd4_q[$];

    // Slave / RAM model: captures the 11 MOSI bits, then serves reads from mem.
    logic [7:0]  mem [256];
    logic [7:0]  wa = 8'h00, ra = 8'h00, rbyte = 8'h00;
    logic [10:0] cap = '0;
    bit          rdf = 1'b0;
    int          lo = 0;
    int          lo4 = 0;
    logic [7:0]  resp4 = 8'h3C;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            lo = 0; rdf = 1'b0; miso = 1'b0;
        end else if (!ss_n) begin
            int k;
            lo++;
            if (lo >= 2 && lo <= 12) cap = {cap[9:0], mosi};
            if (lo == 12) begin
                case (cap[10:8])
                    OP_WR_ADDR: wa = cap[7:0];
                    OP_WR_DATA: mem[wa] = cap[7:0];
                    OP_RD_ADDR: ra = cap[7:0];
                    OP_RD_DATA: begin rbyte = mem[ra]; rdf = 1'b1; end
                    default: ;
                endcase
            end
            k = lo - (13 + TURN);
            if (rdf && k >= 0 && k < 8) miso = rbyte[7-k];
            else miso = 1'b0;
        end else begin
            if (lo != 0) begin
                obs_len.push_back(lo);
                obs_frame.push_back(cap);
            end
            lo = 0; rdf = 1'b0; miso = 1'b0;
        end
        if (rd_valid) obs_rd.push_back(rd_data);

        if (!rst_n) begin
            lo4 = 0; miso4 = 1'b0;
        end else if (!ss4) begin
            lo4++;
            if (lo4 >= 17 && lo4 <= 24) miso4 = resp4[24-lo4];
            else miso4 = 1'b0;
        end else begin
            if (lo4 != 0) len4_q.push_back(lo4);
            lo4 = 0; miso4 = 1'b0;
        end
        if (rv4) rd4_q.push_back(rd4);
    end

    task automatic send(input logic [2:0] op, input logic [7:0] d, input bit hold);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            total++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        exp_frame.push_back({op, d});
        exp_len.push_back((op == OP_RD_DATA) ? LEN_RD : LEN_WR);
    endtask

    task automatic wait_frames(input string name);
        int t = 0;
        while (obs_frame.size() < exp_frame.size() && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) begin
            total++;
            $display("FAIL %s_timeout: frames seen %0d required %0d", name, obs_frame.size(), exp_frame.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ss_n !== 1'b1) $display("FAIL reset_ss_n: got %b required 1", ss_n); else pass_cnt++;
        total++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b required 0", mosi); else pass_cnt++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); else pass_cnt++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b required 0", rd_valid); else pass_cnt++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h required 00", rd_data); else pass_cnt++;
        total++; if (cmd_err !== 1'b0) $display("FAIL reset_cmd_err: got %b required 0", cmd_err); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_addr();
        send(OP_WR_ADDR, 8'h55, 1'b0);
        wait_frames("write_addr");
        while (exp_frame.size() > 0 && obs_frame.size() > 0) begin
            logic [10:0] ef = exp_frame.pop_front();
            logic [10:0] of = obs_frame.pop_front();
            int el = exp_len.pop_front();
            int ol = obs_len.pop_front();
            total++; if (of !== ef) $display("FAIL wa_frame: got %h required %h", of, ef); else pass_cnt++;
            total++; if (ol != el) $display("FAIL wa_ss_len: got %0d required %0d", ol, el); else pass_cnt++;
        end
        total++; if (ss_n !== 1'b1) $display("FAIL wa_ss_after: got %b required 1", ss_n); else pass_cnt++;
    endtask

    task automatic test_read_seq();
        send(OP_WR_DATA, 8'hAA, 1'b0);
        send(OP_RD_ADDR, 8'h55, 1'b0);
        send(OP_RD_DATA, 8'h55, 1'b0);
        exp_rd.push_back(8'hAA);
        wait_frames("read_seq");
        while (exp_frame.size() > 0 && obs_frame.size() > 0) begin
            logic [10:0] ef = exp_frame.pop_front();
            logic [10:0] of = obs_frame.pop_front();
            int el = exp_len.pop_front();
            int ol = obs_len.pop_front();
            total++; if (of !== ef) $display("FAIL rs_frame: got %h required %h", of, ef); else pass_cnt++;
            total++; if (ol != el) $display("FAIL rs_ss_len: got %0d required %0d", ol, el); else pass_cnt++;
        end
        total++; if (obs_rd.size() != 1) $display("FAIL rs_rd_pulses: got %0d required 1", obs_rd.size()); else pass_cnt++;
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [7:0] er = exp_rd.pop_front();
            logic [7:0] orr = obs_rd.pop_front();
            total++; if (orr !== er) $display("FAIL rs_rd_data: got %h required %h", orr, er); else pass_cnt++;
        end
        obs_rd.delete(); exp_rd.delete();
    endtask

    task automatic test_back_to_back();
        int ngaps = 0, bad_gap = 0, bad_rdy = 0, run = 0;
        bit started = 1'b0;
        fork
            begin
                send(OP_WR_ADDR, 8'h21, 1'b1);
                send(OP_WR_DATA, 8'h42, 1'b1);
                send(OP_RD_ADDR, 8'h21, 1'b1);
                send(OP_RD_DATA, 8'h00, 1'b0);
                exp_rd.push_back(8'h42);
            end
            begin
                int t = 0;
                while (obs_frame.size() < 4 && t < 400) begin
                    @(posedge clk);
                    #1;
                    t++;
                    if (cmd_ready !== ss_n) bad_rdy++;
                    if (!ss_n) begin
                        if (started && run != 0) begin
                            ngaps++;
                            if (run != 1) bad_gap++;
                        end
                        started = 1'b1;
                        run = 0;
                    end else begin
                        run++;
                    end
                end
            end
        join
        wait_frames("b2b");
        total++; if (ngaps != 3) $display("FAIL b2b_gaps: got %0d required 3", ngaps); else pass_cnt++;
        total++; if (bad_gap != 0) $display("FAIL b2b_gap_len: got %0d wrong gaps required 0", bad_gap); else pass_cnt++;
        total++; if (bad_rdy != 0) $display("FAIL b2b_cmd_ready: got %0d mismatched cycles required 0", bad_rdy); else pass_cnt++;
        while (exp_frame.size() > 0 && obs_frame.size() > 0) begin
            logic [10:0] ef = exp_frame.pop_front();
            logic [10:0] of = obs_frame.pop_front();
            int el = exp_len.pop_front();
            int ol = obs_len.pop_front();
            total++; if (of !== ef || ol != el) $display("FAIL b2b_frame: got %h/%0d required %h/%0d", of, ol, ef, el); else pass_cnt++;
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [7:0] er = exp_rd.pop_front();
            logic [7:0] orr = obs_rd.pop_front();
            total++; if (orr !== er) $display("FAIL b2b_rd_data: got %h required %h", orr, er); else pass_cnt++;
        end
        obs_rd.delete(); exp_rd.delete();
    endtask

    task automatic test_op_check();
        int low_seen = 0;
        send(3'b010, 8'h5A, 1'b0);
`ifdef SPI_MASTER_OP_CHECK_EN
        void'(exp_frame.pop_back());
        void'(exp_len.pop_back());
        total++; if (cmd_err !== 1'b1) $display("FAIL opchk_err_pulse: got %b required 1", cmd_err); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (cmd_err !== 1'b0) $display("FAIL opchk_err_width: got %b required 0", cmd_err); else pass_cnt++;
        repeat (15) begin
            if (ss_n !== 1'b1) low_seen++;
            @(posedge clk); #1;
        end
        total++; if (low_seen != 0 || obs_frame.size() != 0) $display("FAIL opchk_no_frame: got %0d low cycles required 0", low_seen); else pass_cnt++;
`else
        total++; if (cmd_err !== 1'b0) $display("FAIL opchk_err_tied: got %b required 0", cmd_err); else pass_cnt++;
        wait_frames("opchk");
        while (exp_frame.size() > 0 && obs_frame.size() > 0) begin
            logic [10:0] ef = exp_frame.pop_front();
            logic [10:0] of = obs_frame.pop_front();
            int el = exp_len.pop_front();
            int ol = obs_len.pop_front();
            total++; if (of !== ef) $display("FAIL opchk_frame: got %h required %h", of, ef); else pass_cnt++;
            total++; if (ol != el) $display("FAIL opchk_ss_len: got %0d required %0d low=%0d", ol, el, low_seen); else pass_cnt++;
        end
`endif
        total++; if (rd_data !== 8'h42) $display("FAIL rd_data_hold: got %h required 42", rd_data); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        send(OP_WR_DATA, 8'hC3, 1'b0);
        void'(exp_frame.pop_back());
        void'(exp_len.pop_back());
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (ss_n !== 1'b1) $display("FAIL midrst_ss_n: got %b required 1", ss_n); else pass_cnt++;
        total++; if (mosi !== 1'b0) $display("FAIL midrst_mosi: got %b required 0", mosi); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs_rd.size() != 0 || obs_frame.size() != 0) $display("FAIL midrst_abandon: got %0d rd/%0d frames required 0/0", obs_rd.size(), obs_frame.size()); else pass_cnt++;
        send(OP_WR_ADDR, 8'h12, 1'b0);
        wait_frames("midrst");
        while (exp_frame.size() > 0 && obs_frame.size() > 0) begin
            logic [10:0] ef = exp_frame.pop_front();
            logic [10:0] of = obs_frame.pop_front();
            int el = exp_len.pop_front();
            int ol = obs_len.pop_front();
            total++; if (of !== ef) $display("FAIL midrst_frame: got %h required %h", of, ef); else pass_cnt++;
            total++; if (ol != el) $display("FAIL midrst_ss_len: got %0d required %0d", ol, el); else pass_cnt++;
        end
    endtask

    task automatic test_turn4();
        int t = 0;
        int exp_len4[$];
        logic [7:0] exp_rd4[$];
        len4_q.delete(); rd4_q.delete();
        @(negedge clk);
        v4 = 1'b1; op4 = OP_RD_DATA; d4 = 8'h00;
        @(posedge clk); #1;
        v4 = 1'b0;
        exp_len4.push_back(1 + 11 + 4 + 8 + 1);
        exp_rd4.push_back(8'h3C);
        while (len4_q.size() == 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (len4_q.size() != 1 || rd4_q.size() != 1) $display("FAIL t4_counts: got %0d frames/%0d rd required 1/1", len4_q.size(), rd4_q.size()); else pass_cnt++;
        while (exp_len4.size() > 0 && len4_q.size() > 0) begin
            int el = exp_len4.pop_front();
            int ol = len4_q.pop_front();
            total++; if (ol != el) $display("FAIL t4_ss_len: got %0d required %0d", ol, el); else pass_cnt++;
        end
        while (exp_rd4.size() > 0 && rd4_q.size() > 0) begin
            logic [7:0] er = exp_rd4.pop_front();
            logic [7:0] orr = rd4_q.pop_front();
            total++; if (orr !== er) $display("FAIL t4_rd_data: got %h required %h", orr, er); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_read_seq();
        test_back_to_back();
        test_op_check();
        test_reset_midframe();
        test_turn4();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

`default_nettype wire
